mem_port_arbiter: RTL and testbench

Arbiter and address sequencer for the single-port 256×8 unified memory. It shares the memory between three requesters: instruction fetch, data load/store and stack push/pop. It maps each requester into its fixed region: instruction 0–127, data 128–223, stack 224–255. It owns the stack pointer, and it sits between the core's fetch/execute units and the memory macro.

---
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port 256x8 memory between instruction fetch,
// data load/store and a hardware stack. Grants are combinational, so a granted
// request drives the memory port in the same cycle; read data returns one cycle
// later, tagged with the requester that issued the read.
module mem_port_arbiter #(
  parameter int unsigned DATA_BASE    = 128,
  parameter int unsigned DATA_SIZE    = 96,
  parameter int unsigned STACK_TOP    = 255,
  parameter int unsigned STACK_DEPTH  = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,

  // Instruction fetch
  input  logic       if_req,
  input  logic [7:0] if_addr,
  output logic       if_gnt,
  output logic       if_rvalid,

  // Data load/store
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_gnt,
  output logic       d_rvalid,
  output logic       d_wrap,

  // Stack push/pop
  input  logic       s_req,
  input  logic       s_push,
  input  logic [7:0] s_wdata,
  output logic       s_gnt,
  output logic       s_rvalid,
  output logic       s_err,

  // Read data returned to all requesters
  output logic [7:0] rdata,

  // Memory macro port
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,

  // Stack status
  output logic [7:0] sp,
  output logic       stk_full,
  output logic       stk_empty
);

  localparam logic [7:0] DataBase  = 8'(DATA_BASE);
  localparam logic [6:0] DataSize  = 7'(DATA_SIZE);
  localparam logic [7:0] StackTop  = 8'(STACK_TOP);
  localparam logic [7:0] StackFull = 8'(STACK_TOP - STACK_DEPTH);
  localparam logic [2:0] StarveMax = 3'(STARVE_LIMIT);

  // Owner of the read issued in the current cycle
  typedef enum logic [1:0] {
    TagNone  = 2'd0,
    TagFetch = 2'd1,
    TagData  = 2'd2,
    TagPop   = 2'd3
  } tag_e;

  tag_e       tag_q, tag_d;
  logic [7:0] sp_q, sp_d;
  logic [2:0] starve_q, starve_d;
  logic       d_wrap_q, d_wrap_d;
  logic       s_err_q, s_err_d;

  logic       fetch_forced;
  logic       fetch_win;
  logic       stk_full_c;
  logic       stk_empty_c;
  logic [6:0] d_off_raw;
  logic       d_off_wraps;
  logic [6:0] d_off;
  logic [7:0] d_phys;

  // Bit 7 of the logical fetch/data addresses has no meaning in either region
  logic unused_addr_msb;
  assign unused_addr_msb = ^{if_addr[7], d_addr[7]};

  assign stk_full_c  = (sp_q == StackFull);
  assign stk_empty_c = (sp_q == StackTop);

  // A starved fetch overrides the normal data > stack > fetch order
  assign fetch_forced = if_req && (starve_q == StarveMax);
  assign fetch_win    = if_req && (fetch_forced || (!d_req && !s_req));

  // Fold the 7-bit logical data offset into the data region
  always_comb begin
    d_off_raw   = d_addr[6:0];
    d_off_wraps = (d_off_raw >= DataSize);
    d_off       = d_off_wraps ? (d_off_raw - DataSize) : d_off_raw;
    d_phys      = DataBase + {1'b0, d_off};
  end

  // Grant selection, memory port drive and next stack/tag/pulse state
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    s_gnt     = 1'b0;
    mem_addr  = 8'd0;
    mem_we    = 1'b0;
    mem_wdata = 8'd0;
    tag_d     = TagNone;
    sp_d      = sp_q;
    d_wrap_d  = 1'b0;
    s_err_d   = 1'b0;

    if (fetch_win) begin
      if_gnt   = 1'b1;
      mem_addr = {1'b0, if_addr[6:0]};
      tag_d    = TagFetch;
    end else if (d_req) begin
      d_gnt     = 1'b1;
      mem_addr  = d_phys;
      mem_we    = d_we;
      mem_wdata = d_wdata;
      d_wrap_d  = d_off_wraps;
      tag_d     = d_we ? TagNone : TagData;
    end else if (s_req) begin
      s_gnt = 1'b1;
      if (s_push) begin
        if (stk_full_c) begin
          // Overflow: slot is consumed but memory and sp are left alone
          s_err_d = 1'b1;
        end else begin
          mem_addr  = sp_q;
          mem_we    = 1'b1;
          mem_wdata = s_wdata;
          sp_d      = sp_q - 8'd1;
        end
      end else begin
        if (stk_empty_c) begin
          // Underflow: no read, so no s_rvalid follows
          s_err_d = 1'b1;
        end else begin
          mem_addr = sp_q + 8'd1;
          sp_d     = sp_q + 8'd1;
          tag_d    = TagPop;
        end
      end
    end
  end

  // Starvation counter: counts consecutive denied fetch cycles, saturating
  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = 3'd0;
    end else if (starve_q < StarveMax) begin
      starve_d = starve_q + 3'd1;
    end
  end

  // State registers; reset drops any in-flight read immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q    <= TagNone;
      sp_q     <= StackTop;
      starve_q <= 3'd0;
      d_wrap_q <= 1'b0;
      s_err_q  <= 1'b0;
    end else begin
      tag_q    <= tag_d;
      sp_q     <= sp_d;
      starve_q <= starve_d;
      d_wrap_q <= d_wrap_d;
      s_err_q  <= s_err_d;
    end
  end

  // Decode the read tag into per-requester valid strobes
  always_comb begin
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    s_rvalid  = 1'b0;
    unique case (tag_q)
      TagFetch: if_rvalid = 1'b1;
      TagData:  d_rvalid  = 1'b1;
      TagPop:   s_rvalid  = 1'b1;
      default:  ;
    endcase
  end

  assign rdata     = mem_rdata;
  assign sp        = sp_q;
  assign stk_full  = stk_full_c;
  assign stk_empty = stk_empty_c;
  assign d_wrap    = d_wrap_q;
  assign s_err     = s_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 256x8 synchronous memory model.
// Read responses are checked by a scoreboard monitor; grants and memory port
// values are checked inline during each stimulus cycle.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_req, d_req, d_we, s_req, s_push;
  logic [7:0] if_addr, d_addr, d_wdata, s_wdata;
  logic       if_gnt, if_rvalid, d_gnt, d_rvalid, d_wrap, s_gnt, s_rvalid, s_err;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata, sp;
  logic       mem_we, stk_full, stk_empty;

  typedef struct packed {
    logic [1:0] src;   // 1 fetch, 2 data, 3 pop
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] mem [256];

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_wrap    (d_wrap),
    .s_req     (s_req),
    .s_push    (s_push),
    .s_wdata   (s_wdata),
    .s_gnt     (s_gnt),
    .s_rvalid  (s_rvalid),
    .s_err     (s_err),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .sp        (sp),
    .stk_full  (stk_full),
    .stk_empty (stk_empty)
  );

  always #5 clk = ~clk;

  // Memory model: read returns the pre-write contents, 1-cycle latency
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; d_req = 1'b0; s_req = 1'b0;
  endtask

  // Scoreboard monitor: one grant at most, and every rvalid must match the queue head
  always @(negedge clk) begin : monitor
    logic [1:0] src;
    int         nvalid;
    exp_t       e;
    if (rst) begin
      n_checks++;
      if ((32'(if_gnt) + 32'(d_gnt) + 32'(s_gnt)) > 1) begin
        n_fail++;
        $display("FAIL one_gnt: got %b%b%b, expected at most one", if_gnt, d_gnt, s_gnt);
      end
      nvalid = 32'(if_rvalid) + 32'(d_rvalid) + 32'(s_rvalid);
      if (nvalid != 0) begin
        src = if_rvalid ? 2'd1 : (d_rvalid ? 2'd2 : 2'd3);
        n_checks++;
        if (nvalid > 1) begin
          n_fail++;
          $display("FAIL rvalid_onehot: got %0d strobes, expected 1", nvalid);
        end else if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rvalid_unexpected: got src %0d rdata %0h, expected none", src, rdata);
        end else begin
          e = sb.pop_front();
          if (e.src != src || e.data != rdata) begin
            n_fail++;
            $display("FAIL rdata: got src %0d data %0h, expected src %0d data %0h",
                     src, rdata, e.src, e.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    rst = 1'b0;
    idle_inputs();
    if_addr = 8'd0; d_we = 1'b0; d_addr = 8'd0; d_wdata = 8'd0;
    s_push = 1'b0; s_wdata = 8'd0;

    // Reset and idle
    #12;
    check("rst_sp", sp, 8'd255);
    check("rst_empty", stk_empty, 1'b1);
    check("rst_full", stk_full, 1'b0);
    check("rst_rvalid", {if_rvalid, d_rvalid, s_rvalid}, 3'b000);
    check("rst_pulses", {d_wrap, s_err}, 2'b00);
    check("rst_gnt", {if_gnt, d_gnt, s_gnt}, 3'b000);
    check("rst_mem", {mem_addr, mem_we}, 9'd0);
    #10 rst = 1'b1;
    tick();
    check("idle_mem", {mem_addr, mem_we, mem_wdata}, 17'd0);

    // Fetch read: 0xC5 maps to 0x45, contents 0x45^0x5A
    if_req = 1'b1; if_addr = 8'hC5;
    #2;
    check("if_gnt", if_gnt, 1'b1);
    check("if_addr", {mem_addr, mem_we}, {8'h45, 1'b0});
    sb.push_back('{src: 2'd1, data: 8'h1F});
    tick(); idle_inputs();

    // Data store at logical 5 -> 133
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h05; d_wdata = 8'hAA;
    #2;
    check("d_store_gnt", d_gnt, 1'b1);
    check("d_store_port", {mem_addr, mem_we, mem_wdata}, {8'd133, 1'b1, 8'hAA});
    tick(); idle_inputs();
    check("d_store_nowrap", d_wrap, 1'b0);

    // Data load at logical 100 wraps to 132, contents 132^0x5A
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h64;
    #2;
    check("d_load_port", {mem_addr, mem_we}, {8'd132, 1'b0});
    sb.push_back('{src: 2'd2, data: 8'hDE});
    tick(); idle_inputs();
    check("d_wrap_pulse", d_wrap, 1'b1);
    tick();
    check("d_wrap_clear", d_wrap, 1'b0);

    // Load back the stored byte
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05;
    #2;
    check("d_reload_addr", mem_addr, 8'd133);
    sb.push_back('{src: 2'd2, data: 8'hAA});
    tick(); idle_inputs();

    // Stack push/push/pop/pop/underflow
    s_req = 1'b1; s_push = 1'b1; s_wdata = 8'h11;
    #2;
    check("push1_port", {s_gnt, mem_addr, mem_we, mem_wdata}, {1'b1, 8'd255, 1'b1, 8'h11});
    tick();
    check("push1_sp", {sp, stk_empty}, {8'd254, 1'b0});
    s_wdata = 8'h22;
    #2;
    check("push2_addr", mem_addr, 8'd254);
    tick();
    check("push2_sp", sp, 8'd253);
    s_push = 1'b0;
    #2;
    check("pop1_port", {mem_addr, mem_we}, {8'd254, 1'b0});
    sb.push_back('{src: 2'd3, data: 8'h22});
    tick();
    check("pop1_sp", sp, 8'd254);
    #2;
    check("pop2_addr", mem_addr, 8'd255);
    sb.push_back('{src: 2'd3, data: 8'h11});
    tick();
    check("pop2_sp", {sp, stk_empty}, {8'd255, 1'b1});
    #2;
    check("underflow_port", {s_gnt, mem_addr, mem_we}, {1'b1, 8'd0, 1'b0});
    tick(); idle_inputs();
    check("underflow_err", {s_err, sp}, {1'b1, 8'd255});
    tick();
    check("underflow_err_clear", s_err, 1'b0);

    // 32 pushes fill the stack: data 0x80+i at address 255-i
    s_req = 1'b1; s_push = 1'b1;
    for (int i = 0; i < 32; i++) begin
      s_wdata = 8'(8'h80 + i);
      #2;
      check("fill_addr", mem_addr, 32'(255 - i));
      tick();
    end
    check("full_state", {sp, stk_full, stk_empty}, {8'd223, 1'b1, 1'b0});
    s_wdata = 8'hEE;
    #2;
    check("overflow_port", {s_gnt, mem_we, mem_addr}, {1'b1, 1'b0, 8'd0});
    tick(); idle_inputs();
    check("overflow_err", {s_err, sp}, {1'b1, 8'd223});
    tick();

    // All three requesting: data wins 0-3, starved fetch wins 4, data again 5
    if_req = 1'b1; if_addr = 8'h02;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 8'h77;
    s_req = 1'b1; s_push = 1'b1;
    sb.push_back('{src: 2'd1, data: 8'h58});
    for (int c = 0; c < 6; c++) begin
      #2;
      check("arb3_gnt", {if_gnt, d_gnt, s_gnt}, (c == 4) ? 3'b100 : 3'b010);
      tick();
    end
    idle_inputs();
    tick();

    // Fetch vs stack pops: stack wins 0-3, fetch wins 4, stack again 5
    if_req = 1'b1; s_req = 1'b1; s_push = 1'b0;
    sb.push_back('{src: 2'd3, data: 8'h9F});
    sb.push_back('{src: 2'd3, data: 8'h9E});
    sb.push_back('{src: 2'd3, data: 8'h9D});
    sb.push_back('{src: 2'd3, data: 8'h9C});
    sb.push_back('{src: 2'd1, data: 8'h58});
    sb.push_back('{src: 2'd3, data: 8'h9B});
    for (int c = 0; c < 6; c++) begin
      #2;
      check("arb2_gnt", {if_gnt, d_gnt, s_gnt}, (c == 4) ? 3'b100 : 3'b001);
      tick();
    end
    idle_inputs();
    check("arb2_sp", sp, 8'd228);
    tick();

    // Reset mid-read: the pending data rvalid must vanish at once
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05;
    #2;
    check("midrst_gnt", d_gnt, 1'b1);
    tick(); idle_inputs();
    check("midrst_rvalid_before", d_rvalid, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst_rvalid", d_rvalid, 1'b0);
    check("midrst_sp", {sp, stk_empty}, {8'd255, 1'b1});
    #17 rst = 1'b1;
    repeat (3) tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
